// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit for the EX stage: XLEN-cycle shift-add multiply
// and restoring divide, with pipeline stall/over handshake and a HI/LO write strobe.
`timescale 1ns/1ps
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            md_req,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [1:0]      ex_cond,
  output logic            mult_div_stall,
  output logic            mult_div_over,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out,
  output logic            hilo_we
);
  // EX cond encoding: 00 flow, 01 stall, 10 zero (flushed)
  localparam logic [1:0] COND_ZERO = 2'b10;
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;

  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opnd, hi_q, lo_q;
  logic              is_div, neg_q, neg_r, dz;
  logic              accept, abort;

  logic              sa, sb;
  logic [XLEN-1:0]   a_abs, b_abs;
  assign sa    = md_op[0] & rs_data[XLEN-1];
  assign sb    = md_op[0] & rt_data[XLEN-1];
  assign a_abs = sa ? (~rs_data + 1'b1) : rs_data;
  assign b_abs = sb ? (~rt_data + 1'b1) : rt_data;

  // Multiply step: multiplier sits in acc low half and shifts out LSB first.
  logic [XLEN:0] msum;
  assign msum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};

  // Divide step: acc = {remainder, dividend}; dividend shifts out MSB first.
  logic [XLEN:0]   dsh;
  logic [XLEN-1:0] dsub, drem;
  logic            dge;
  assign dsh  = acc[2*XLEN-1:XLEN-1];
  assign dge  = dsh >= {1'b0, opnd};
  assign dsub = dsh[XLEN-1:0] - opnd;
  assign drem = dge ? dsub : dsh[XLEN-1:0];

  always_comb begin
    state_d        = state;
    accept         = 1'b0;
    mult_div_stall = 1'b0;
    mult_div_over  = 1'b0;
    hilo_we        = 1'b0;
    abort          = (ex_cond == COND_ZERO);
    case (state)
      IDLE: begin
        mult_div_stall = md_req && !abort;
        if (md_req && !abort) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        mult_div_stall = 1'b1;
        if (abort)                         state_d = IDLE;
        else if (cnt == CW'(XLEN-1))       state_d = DONE;
      end
      DONE: begin
        mult_div_stall = 1'b1;
        mult_div_over  = 1'b1;
        hilo_we        = !abort;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sign fix-up of the magnitude result; divide by zero forces an all-ones quotient.
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem, res_hi, res_lo;
  assign prod   = neg_q ? (~acc + 1'b1) : acc;
  assign quo    = dz ? '1 : (neg_q ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0]);
  assign rem    = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
  assign res_hi = is_div ? rem : prod[2*XLEN-1:XLEN];
  assign res_lo = is_div ? quo : prod[XLEN-1:0];

  // Result shows on the outputs in the DONE cycle and is held afterwards.
  assign hi_out = hilo_we ? res_hi : hi_q;
  assign lo_out = hilo_we ? res_lo : lo_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        is_div <= md_op[1];
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        dz     <= md_op[1] && (rt_data == '0);
        cnt    <= '0;
        opnd   <= md_op[1] ? b_abs : a_abs;
        acc    <= {{XLEN{1'b0}}, (md_op[1] ? a_abs : b_abs)};
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? {drem, acc[XLEN-2:0], dge} : {msum, acc[XLEN-1:1]};
      end
      if (hilo_we) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, randomized ops
// against an arithmetic reference, abort, reset and back-to-back sequences.
`timescale 1ns/1ps
module tb_mult_div_unit;
  localparam logic [1:0] COND_FLOW = 2'b00, COND_STALL = 2'b01, COND_ZERO = 2'b10;
  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_req;
  logic [1:0]  md_op;
  logic [31:0] rs_data, rt_data;
  logic [1:0]  ex_cond;
  logic        mult_div_stall, mult_div_over, hilo_we;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  mult_div_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .md_req(md_req), .md_op(md_op),
    .rs_data(rs_data), .rt_data(rt_data), .ex_cond(ex_cond),
    .mult_div_stall(mult_div_stall), .mult_div_over(mult_div_over),
    .hi_out(hi_out), .lo_out(lo_out), .hilo_we(hilo_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, got, exp);
    end
  endtask

  // Architectural result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sp;
    int q, r;
    case (op)
      MULTU: return {32'b0, a} * {32'b0, b};
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  // Presents one request and follows it until over; operands and op are scrambled
  // after acceptance and ex_cond is STALL for a few RUN cycles.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int stall_n, output int over_at,
                        output int we_at, output int we_n);
    stall_n = 0; over_at = -1; we_at = -1; we_n = 0; res = '0;
    @(posedge clk); #1;
    md_req = 1'b1; md_op = op; rs_data = a; rt_data = b; ex_cond = COND_FLOW;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        rs_data = $urandom; rt_data = $urandom; md_op = 2'($urandom);
        ex_cond = (c >= 5 && c <= 8) ? COND_STALL : COND_FLOW;
      end
      @(negedge clk);
      if (mult_div_stall) stall_n++;
      if (hilo_we) begin we_n++; we_at = c; res = {hi_out, lo_out}; end
      if (mult_div_over) begin
        over_at = c;
        md_req = 1'b0;
        break;
      end
    end
    ex_cond = COND_FLOW;
  endtask

  logic [63:0] res, prev, exp;
  int stall_n, over_at, we_at, we_n;
  logic [1:0]  rop;
  logic [31:0] ra, rb;
  int we_cyc[2];
  logic [63:0] we_val[2];

  initial begin
    vecs[0] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB};
    vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
    vecs[3] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
    vecs[4] = '{DIVU,  32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF};
    vecs[5] = '{DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E};
    vecs[6] = '{DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF};
    vecs[7] = '{MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[8] = '{DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF};

    reset = 1'b0; md_req = 1'b0; md_op = '0; rs_data = '0; rt_data = '0; ex_cond = COND_FLOW;
    #12;
    chk("reset_hilo",  {hi_out, lo_out}, 64'h0);
    chk("reset_we",    hilo_we, 0);
    chk("reset_over",  mult_div_over, 0);
    chk("reset_stall", mult_div_stall, 0);
    @(negedge clk); reset = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, stall_n, over_at, we_at, we_n);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_stall_cycles", i), stall_n, 34);
      chk($sformatf("vec%0d_over_cycle", i), over_at, 33);
      chk($sformatf("vec%0d_we_cycle", i), we_at, 33);
      chk($sformatf("vec%0d_we_count", i), we_n, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d_idle_we", i), hilo_we, 0);
      chk($sformatf("vec%0d_idle_stall", i), mult_div_stall, 0);
      chk($sformatf("vec%0d_hold", i), {hi_out, lo_out}, vecs[i].exp);
    end

    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = -rb;
      exp = ref_model(rop, ra, rb);
      run_op(rop, ra, rb, res, stall_n, over_at, we_at, we_n);
      chk($sformatf("rand%0d_op%0d_%h_%h", n, rop, ra, rb), res, exp);
      chk($sformatf("rand%0d_we_cycle", n), we_at, 33);
    end

    // Abort: ex_cond goes ZERO during cycle 10 of a mult.
    prev = {hi_out, lo_out};
    @(posedge clk); #1;
    md_req = 1'b1; md_op = MULT; rs_data = 32'd5; rt_data = 32'd9; ex_cond = COND_FLOW;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
    end
    ex_cond = COND_ZERO;
    @(negedge clk);
    chk("abort_run_stall", mult_div_stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle_stall", mult_div_stall, 0);
    chk("abort_idle_over", mult_div_over, 0);
    md_req = 1'b0; ex_cond = COND_FLOW;
    we_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_we) we_n++;
    end
    chk("abort_we_count", we_n, 0);
    chk("abort_hilo_held", {hi_out, lo_out}, prev);

    // Reset in cycle 20 of a divide.
    @(posedge clk); #1;
    md_req = 1'b1; md_op = DIVU; rs_data = 32'd1000; rt_data = 32'd3;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b0; md_req = 1'b0;
    #1;
    chk("midreset_hilo",  {hi_out, lo_out}, 64'h0);
    chk("midreset_we",    hilo_we, 0);
    chk("midreset_over",  mult_div_over, 0);
    chk("midreset_stall", mult_div_stall, 0);
    @(negedge clk); reset = 1'b1;
    we_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_we || mult_div_stall) we_n++;
    end
    chk("midreset_no_activity", we_n, 0);
    chk("midreset_hilo_after", {hi_out, lo_out}, 64'h0);

    // Back-to-back: md_req stays high across DONE; the second op is a new divu.
    we_n = 0; we_cyc[0] = -1; we_cyc[1] = -1; we_val[0] = '0; we_val[1] = '0;
    @(posedge clk); #1;
    md_req = 1'b1; md_op = MULT; rs_data = 32'h0001_2345; rt_data = 32'hFFFF_F889;
    for (int c = 0; c < 90; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      if (hilo_we) begin
        if (we_n < 2) begin we_cyc[we_n] = c; we_val[we_n] = {hi_out, lo_out}; end
        we_n++;
        if (we_n == 1) begin md_op = DIVU; rs_data = 32'hDEAD_BEEF; rt_data = 32'h0000_1234; end
        else md_req = 1'b0;
      end
    end
    md_req = 1'b0;
    chk("b2b_we_count", we_n, 2);
    chk("b2b_first_cycle", we_cyc[0], 33);
    chk("b2b_second_cycle", we_cyc[1], 67);
    chk("b2b_first_result", we_val[0], ref_model(MULT, 32'h0001_2345, 32'hFFFF_F889));
    chk("b2b_second_result", we_val[1], ref_model(DIVU, 32'hDEAD_BEEF, 32'h0000_1234));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the EX stage.
- Drives the mult_div_stall / mult_div_over pair consumed by the pipeline flow controller.
- Takes the EX-stage cond back from the flow controller, so that a zeroed EX aborts an operation.
- Produces the 64-bit HI/LO result and a one-cycle HI/LO write strobe.

Parameters:
- XLEN, 32, operand width; iteration count equals XLEN.

Ports:
- clk  in  1  system clock
- reset  in  1  one clock; reset is asynchronous and active-low
- md_req  in  1  EX stage holds a mult/multu/div/divu instruction
- md_op  in  2  operation: 00 multu, 01 mult, 10 divu, 11 div
- rs_data  in  XLEN  operand A / dividend
- rt_data  in  XLEN  operand B / divisor
- ex_cond  in  2  EX-stage cond from the flow controller (PARTS_COND_FLOW / STALL / ZERO)
- mult_div_stall  out  1  operation in progress; EX must hold
- mult_div_over  out  1  result valid this cycle; releases the pipeline
- hi_out  out  XLEN  HI result (product upper half, or remainder)
- lo_out  out  XLEN  LO result (product lower half, or quotient)
- hilo_we  out  1  one-cycle HI/LO write strobe

Behaviour:
- Reset (reset low, asynchronous):
  - state goes to IDLE.
  - The counter and all internal registers clear to 0.
  - hi_out, lo_out, hilo_we and mult_div_over all read 0.
- Reset mid-operation discards the operation with no write.
- States: IDLE, RUN, DONE.
- IDLE:
  - mult_div_stall = md_req && ex_cond != ZERO (combinational); mult_div_over = 0.
  - When md_req is high and ex_cond != ZERO:
    - latch md_op;
    - latch |rs_data| and |rt_data| (absolute value only for signed ops);
    - latch result-sign flags;
    - clear the partial-result registers; set cnt = 0; go to RUN.
- RUN:
  - mult_div_stall = 1; mult_div_over = 0.
  - One iteration per cycle; cnt increments.
  - When cnt == XLEN-1, go to DONE.
  - Multiply: shift-add, LSB of the multiplier first, into a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, MSB first, giving a quotient and a remainder.
- DONE:
  - mult_div_stall = 1 and mult_div_over = 1 for exactly one cycle.
  - hilo_we = 1 for the same cycle, registered with hi_out/lo_out already valid.
  - Go to IDLE next cycle.
  - md_req seen in the following IDLE cycle is treated as a new instruction, because the flow controller advances EX when over is high.
- Latency: request accepted in cycle 0; RUN in cycles 1..XLEN; DONE in cycle XLEN+1 (33 for XLEN=32).
  - The stall is high for every one of those XLEN+2 cycles.
- Abort: ex_cond == ZERO in RUN or DONE means next state IDLE, hilo_we suppressed, hi_out/lo_out unchanged.
  - This covers overflow-flush priority.
- ex_cond == STALL in RUN has no effect; iteration continues.
- Sign rules:
  - mult: result negated (2's complement over 2*XLEN) when sign(A) != sign(B).
  - div: quotient negated when signs differ; remainder takes the sign of the dividend.
  - div of -2^31 by -1 gives LO = 0x80000000, HI = 0.
- Divide by zero (divisor 0, divu or div):
  - LO = all ones and HI = dividend, before any sign correction.
  - Full latency is still taken.
- hi_out/lo_out hold their last written value between operations.
- md_op, rs_data and rt_data are sampled only on IDLE acceptance; later changes are ignored.

Test Plan:
- multu 0xFFFFFFFF × 0xFFFFFFFF:
  - stall high cycles 0..33; over and hilo_we high only in cycle 33;
  - HI = 0xFFFFFFFE, LO = 0x00000001.
- mult -3 × 7 → HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- div with signed operands:
  - -7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- divu 100 / 0:
  - LO = 0xFFFFFFFF, HI = 100 after 34 stall cycles;
  - divu 100 / 7 → LO = 14, HI = 2.
- Abort paths:
  - ex_cond = ZERO at cycle 10 of a mult → IDLE next cycle, no hilo_we, HI/LO unchanged.
  - reset low at cycle 20 → all outputs 0 immediately.
- Back-to-back: mult immediately followed by divu (md_req held high across the DONE edge) → two distinct operations, two hilo_we pulses 34 cycles apart, both results correct.
